// File: rtl/dfr_reservoir_stream.sv
// Delayed-feedback reservoir stage with valid/ready input, selectable nonlinearity,
// feedback gain/truncation, frame tracking and a multi-cycle flush that zeroes the delay line.
module dfr_reservoir_stream #(
    parameter int VIRTUAL_NODES  = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_BITS      = 12,
    parameter int FEEDBACK_SHIFT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             reservoir_en,
    input  logic                             linear_mode,
    input  logic                             flush,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            mg_sum,
    input  logic [DATA_WIDTH-1:0]            mg_result,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             out_valid,
    output logic [$clog2(VIRTUAL_NODES)-1:0] node_idx,
    output logic                             frame_done,
    output logic                             busy
);

    localparam int IDX_W = $clog2(VIRTUAL_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VIRTUAL_NODES - 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] node [VIRTUAL_NODES];
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] fmt;
    logic [DATA_WIDTH-1:0] fb;
    logic [DATA_WIDTH-1:0] node_in;
    logic [DATA_WIDTH-1:0] shift_in;
    logic [IDX_W-1:0]      flush_cnt;
    logic                  accept;
    logic                  shift_en;
    logic                  flush_last;

    // Left-shifting the tail moves its low KEEP_BITS to the top and zero-fills below,
    // which also covers KEEP_BITS == DATA_WIDTH without a zero-width replication.
    assign tail       = node[VIRTUAL_NODES-1];
    assign fmt        = tail << (DATA_WIDTH - KEEP_BITS);
    assign fb         = fmt >> FEEDBACK_SHIFT;
    assign mg_sum     = din + fb;
    assign node_in    = linear_mode ? mg_sum : mg_result;
    assign flush_last = (state == FLUSH) && (flush_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   if (flush_last) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A flush request masks in_ready in the same cycle, so a coincident sample is dropped.
    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        busy     = 1'b0;
        shift_en = 1'b0;
        shift_in = '0;
        case (state)
            RUN: begin
                in_ready = reservoir_en && !flush;
                accept   = in_valid && reservoir_en && !flush;
                shift_en = accept;
                shift_in = node_in;
            end
            FLUSH: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_last ? '0 : flush_cnt + IDX_W'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < VIRTUAL_NODES; k++) begin
                node[k] <= '0;
            end
        end else if (shift_en) begin
            node[0] <= shift_in;
            for (int k = 1; k < VIRTUAL_NODES; k++) begin
                node[k] <= node[k-1];
            end
        end
    end

    // dout carries the formatted pre-shift tail; node_idx returns to 0 once a flush completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            node_idx   <= '0;
        end else begin
            out_valid  <= accept;
            frame_done <= accept && (node_idx == LAST_IDX);
            if (accept) begin
                dout     <= fmt;
                node_idx <= (node_idx == LAST_IDX) ? '0 : node_idx + IDX_W'(1);
            end else if (flush_last) begin
                node_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dfr_reservoir_stream.sv
// Scoreboard bench for dfr_reservoir_stream: stimulus pushes expected dout/frame_done,
// a posedge-offset monitor pops and compares on every out_valid.
module tb_dfr_reservoir_stream;

    logic        clk;
    logic        rst;
    logic        reservoir_en;
    logic        linear_mode;
    logic        flush;
    logic [31:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mg_sum;
    logic [31:0] mg_result;
    logic [31:0] dout;
    logic        out_valid;
    logic [1:0]  node_idx;
    logic        frame_done;
    logic        busy;

    logic        in_ready_b;
    logic [31:0] mg_sum_b;
    logic [31:0] mg_result_b;
    logic [31:0] dout_b;
    logic        out_valid_b;
    logic [1:0]  node_idx_b;
    logic        frame_done_b;
    logic        busy_b;

    int compared;
    int mismatched;
    logic [32:0] exp_q[$];

    // Stand-in for the external nonlinearity: halve the operand.
    assign mg_result   = mg_sum >> 1;
    assign mg_result_b = mg_sum_b >> 1;

    dfr_reservoir_stream #(
        .VIRTUAL_NODES(4), .DATA_WIDTH(32), .KEEP_BITS(12), .FEEDBACK_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .reservoir_en(reservoir_en), .linear_mode(linear_mode),
        .flush(flush), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .mg_sum(mg_sum), .mg_result(mg_result), .dout(dout), .out_valid(out_valid),
        .node_idx(node_idx), .frame_done(frame_done), .busy(busy)
    );

    dfr_reservoir_stream #(
        .VIRTUAL_NODES(4), .DATA_WIDTH(32), .KEEP_BITS(12), .FEEDBACK_SHIFT(4)
    ) dut_gain (
        .clk(clk), .rst(rst), .reservoir_en(reservoir_en), .linear_mode(linear_mode),
        .flush(flush), .din(din), .in_valid(in_valid), .in_ready(in_ready_b),
        .mg_sum(mg_sum_b), .mg_result(mg_result_b), .dout(dout_b), .out_valid(out_valid_b),
        .node_idx(node_idx_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic en,
                                 input logic lin, input logic fl);
        @(negedge clk);
        in_valid     = v;
        din          = d;
        reservoir_en = en;
        linear_mode  = lin;
        flush        = fl;
        #1;
    endtask

    task automatic sendSample(input logic [31:0] d, input logic lin,
                              input logic [31:0] exp_dout, input logic exp_fd);
        applyStimulus(1'b1, d, 1'b1, lin, 1'b0);
        checkOutput("accept_ready", {31'b0, in_ready}, 32'h1);
        exp_q.push_back({exp_fd, exp_dout});
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got dout 0x%08h, expected no output", dout);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                checkOutput("dout", dout, e[31:0]);
                checkOutput("frame_done", {31'b0, frame_done}, {31'b0, e[32]});
            end
        end else if (frame_done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL stray_frame_done: got 1, expected 0");
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b0;
        reservoir_en = 1'b0;
        linear_mode  = 1'b1;
        flush        = 1'b0;
        din          = '0;
        in_valid     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] reset state");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("rst_dout", dout, 32'h0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_node_idx", {30'b0, node_idx}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);

        $display("[TB] linear fill and feedback");
        sendSample(32'h00000ABC, 1'b1, 32'h0, 1'b0);
        sendSample(32'h0, 1'b1, 32'h0, 1'b0);
        sendSample(32'h0, 1'b1, 32'h0, 1'b0);
        sendSample(32'h0, 1'b1, 32'h0, 1'b1);
        sendSample(32'h0, 1'b1, 32'hABC00000, 1'b0);
        checkOutput("fb_sum", mg_sum, 32'hABC00000);
        checkOutput("gain_sum", mg_sum_b, 32'h0ABC0000);

        $display("[TB] carry wrap");
        sendSample(32'h00000001, 1'b1, 32'h0, 1'b0);
        sendSample(32'h0, 1'b1, 32'h0, 1'b0);
        sendSample(32'h0, 1'b1, 32'h0, 1'b1);
        sendSample(32'h0, 1'b1, 32'h0, 1'b0);
        sendSample(32'hFFFFFFFF, 1'b1, 32'h00100000, 1'b0);
        checkOutput("wrap_sum", mg_sum, 32'h000FFFFF);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h123, 1'b0, 1'b1, 1'b0);
        checkOutput("en_low_ready", {31'b0, in_ready}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("en_low_idx", {30'b0, node_idx}, 32'h2);

        $display("[TB] flush wins over valid");
        applyStimulus(1'b1, 32'h777, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_ready", {31'b0, in_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h777, 1'b1, 1'b1, (i == 1));
            checkOutput("flush_busy", {31'b0, busy}, 32'h1);
            checkOutput("flush_in_ready", {31'b0, in_ready}, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("post_flush_busy", {31'b0, busy}, 32'h0);
        checkOutput("post_flush_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("post_flush_idx", {30'b0, node_idx}, 32'h0);
        sendSample(32'h5, 1'b1, 32'h0, 1'b0);
        sendSample(32'h5, 1'b1, 32'h0, 1'b0);
        sendSample(32'h5, 1'b1, 32'h0, 1'b0);
        sendSample(32'h5, 1'b1, 32'h0, 1'b1);
        sendSample(32'h0, 1'b1, 32'h00500000, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        $display("[TB] async reset during flush");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, busy}, 32'h0);
        checkOutput("arst_dout", dout, 32'h0);
        checkOutput("arst_idx", {30'b0, node_idx}, 32'h0);
        checkOutput("arst_in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("arst_run_busy", {31'b0, busy}, 32'h0);

        $display("[TB] nonlinear path");
        sendSample(32'h00000100, 1'b0, 32'h0, 1'b0);
        sendSample(32'h0, 1'b0, 32'h0, 1'b0);
        sendSample(32'h0, 1'b0, 32'h0, 1'b0);
        sendSample(32'h0, 1'b0, 32'h0, 1'b1);
        sendSample(32'h0, 1'b1, 32'h08000000, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dfr_reservoir_stream.md
Name: dfr_reservoir_stream

Overview:
- Parametrised delayed-feedback reservoir with a valid/ready input handshake, a selectable nonlinearity (external Mackey-Glass block or linear bypass), a configurable feedback gain and output truncation, frame tracking, and a multi-cycle flush sequencer.
- Sits between the input-masking stage and the readout stage of the hybrid DFR datapath.
- Successor to the fixed-depth reservoir: it adds backpressure, flush and mode control.

Parameters:
- VIRTUAL_NODES, 10, delay-line depth (>=2).
- DATA_WIDTH, 32, sample width.
- KEEP_BITS, 12, low tail bits kept for feedback/output (1..DATA_WIDTH).
- FEEDBACK_SHIFT, 0, logical right shift applied to the feedback term (gain 2^-N), 0..DATA_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- reservoir_en  in  1  enables acceptance
- linear_mode  in  1  1 = bypass nonlinearity
- flush  in  1  request to zero the delay line
- din  in  DATA_WIDTH  masked input sample
- in_valid  in  1  din valid
- in_ready  out  1  block can accept
- mg_sum  out  DATA_WIDTH  operand to external nonlinearity
- mg_result  in  DATA_WIDTH  combinational result of nonlinearity(mg_sum)
- dout  out  DATA_WIDTH  registered formatted feedback sample
- out_valid  out  1  dout valid, one-cycle pulse
- node_idx  out  $clog2(VIRTUAL_NODES)  virtual node index of next accept
- frame_done  out  1  pulse: last node of a frame accepted
- busy  out  1  flush in progress

Behaviour:
- Reset (rst low, async):
  - all nodes, dout, node_idx, flush counter = 0
  - out_valid, frame_done, busy = 0
  - state RUN
- Storage: shift register node[0..VIRTUAL_NODES-1]; tail = node[VIRTUAL_NODES-1].
- Feedback formatting:
  - fmt = {tail[KEEP_BITS-1:0], (DATA_WIDTH-KEEP_BITS) zeros}
  - fb = fmt >> FEEDBACK_SHIFT (logical shift)
- Sum and node input:
  - mg_sum = din + fb, modulo 2^DATA_WIDTH (carry discarded); combinational, always driven.
  - node input = linear_mode ? mg_sum : mg_result.
- Handshake:
  - in_ready = reservoir_en && state==RUN && !flush (combinational).
  - Accept = in_valid && in_ready.
- On accept, at the clock edge:
  - node[0] <= node input; node[k] <= node[k-1].
  - dout <= fmt computed from the pre-shift tail.
  - out_valid <= 1, otherwise 0 (latency one cycle from accept).
  - node_idx increments, wrapping VIRTUAL_NODES-1 -> 0; frame_done <= 1 on that wrap accept, otherwise 0.
- No accept: nodes, dout and node_idx hold; out_valid and frame_done are 0.
- FSM states RUN and FLUSH:
  - RUN -> FLUSH when flush=1, whatever in_valid/reservoir_en are; a flush in the same cycle as in_valid wins and the sample is not accepted.
  - FLUSH: shift zeros in, one node per cycle, for exactly VIRTUAL_NODES cycles (counter 0..VIRTUAL_NODES-1). busy=1; in_ready=0; flush input ignored; no out_valid.
  - FLUSH -> RUN after the final cycle: all nodes 0, node_idx=0, dout unchanged.
- linear_mode and reservoir_en may change any cycle; they are sampled only on accept.
- Async reset mid-flush or mid-frame returns to the reset state immediately.

Test Plan (VIRTUAL_NODES=4, DATA_WIDTH=32, KEEP_BITS=12, FEEDBACK_SHIFT=0 unless noted):
1. Reset then reservoir_en=1, in_valid=0 -> in_ready=1; dout=0, out_valid=0, node_idx=0, busy=0.
2. linear_mode=1; accept 0x00000ABC, then 0, 0, 0, 0:
   - the 5th accept gives dout=0xABC00000 with out_valid one cycle later;
   - node[0]=0xABC00000;
   - frame_done pulses after the 4th accept.
3. Wrap and gain:
   - tail low bits 0x001 and din=0xFFFFFFFF -> mg_sum=0x000FFFFF.
   - With FEEDBACK_SHIFT=4, tail=0xABC and din=0 -> mg_sum=0x0ABC0000.
4. linear_mode=0, mg_result driven as mg_sum>>1; accept din=0x00000100 from an empty line -> node[0]=0x00000080.
5. Backpressure and flush:
   - reservoir_en=0 with in_valid=1 -> no accept, state unchanged.
   - flush=1 with in_valid=1 mid-frame (node_idx=2) -> sample dropped; busy and in_ready=0 for exactly 4 cycles; then all nodes 0, node_idx=0, in_ready=1.
6. rst low asynchronously during FLUSH cycle 2 -> outputs at reset values before the next edge; after release, state RUN.
